echo_accum: RTL and testbench
=============================

# echo_accum

Parametrised, count-terminated sample accumulator for NMR echo stacking. It is the next generation of the free-running 12-to-20-bit adder register. It sums a programmed number of valid samples per acquisition and selects saturating or wrapping overflow. It adds a start/abort handshake, a one-cycle result strobe and a sticky overflow flag. It sits between the ADC sample path and the echo-result readout registers.

## Interface
- IN_W, 12, input sample width (unsigned)
- ACC_W, 20, accumulator/result width; ACC_W >= IN_W
- CNT_W, 10, sample-count width
- SAT, 1, 1 = saturate at 2^ACC_W-1 on overflow, 0 = wrap modulo 2^ACC_W

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk
- start  in  1  one-cycle request to begin an acquisition
- n_samples  in  CNT_W  samples to accumulate; latched on accepted start
- abort  in  1  terminate the acquisition without a result
- din  in  IN_W  sample data
- din_valid  in  1  din is valid this cycle
- busy  out  1  acquisition in progress (state ACC)
- result  out  ACC_W  final sum; holds until the next result strobe
- result_valid  out  1  one-cycle strobe, result updated
- ovf  out  1  overflow occurred in the last completed acquisition

## Operation
- States: IDLE, ACC, DONE.
- IDLE:
  - start=1 with n_samples>0: latch n_samples, clear acc and the sample count, clear the internal overflow, go to ACC.
  - start=1 with n_samples=0: latch n_samples, clear acc, go directly to DONE. This produces result=0 and ovf=0.
- ACC:
  - Each cycle with din_valid=1: acc <= acc + din, zero-extended to ACC_W+1 bits, and count increments.
  - SAT=1: if the sum is >= 2^ACC_W, acc <= 2^ACC_W-1 and the internal overflow flag is set. Once saturated, acc stays at max.
  - SAT=0: acc takes the low ACC_W bits of the sum. The overflow flag is set on any carry out.
  - On the edge that accepts sample number n_samples: the updated sum goes into result, the internal flag (including this sample's overflow) goes into ovf, and the state moves to DONE.
  - din_valid=0 cycles are gaps: no change.
  - start in ACC is ignored; n_samples is not re-latched.
- DONE: result_valid=1 for exactly this cycle; next state IDLE. start is ignored in DONE.
- abort=1 in ACC or DONE: next state IDLE. If in ACC, result, ovf and result_valid are left unchanged (no strobe). abort has priority over sample acceptance and completion in the same cycle. abort in IDLE has no effect. If abort and start are high together in IDLE, start wins.
- Reset overrides everything on the clock edge.

## Timing
- Reset values: state IDLE, busy=0, result=0, result_valid=0, ovf=0, internal acc=0, count=0.
- busy=1 starting the cycle after the accepting start edge, through the cycle whose edge accepts the last sample.
- result and ovf change on the last-sample edge. result_valid is high for the following cycle.
- Latency from the last valid sample to result_valid is 1 cycle.
- Minimum start-to-start spacing with N samples and no gaps is N+2 cycles.
- A reset asserted mid-acquisition discards the partial sum. No result_valid is issued.

## Test plan
- SAT=1, n_samples=4, din=100 for 4 consecutive valid cycles -> one result_valid pulse, result=400, ovf=0, busy high for exactly 4 cycles.
- n_samples=3, din=7, 9, 11 with din_valid gaps of 0, 2 and 5 cycles between them -> result=27 one cycle after the 3rd valid. Start pulses issued mid-acquisition are ignored.
- Default widths, n_samples=300, din=4095 every cycle:
  - SAT=1 -> result=1048575, ovf=1.
  - SAT=0 -> result=179924 (1228500 mod 2^20), ovf=1.
  - A following start with n_samples=2, din=1, 1 -> result=2, ovf=0.
- start with n_samples=0 -> result_valid 1 cycle later with result=0, ovf=0, busy never high.
- Interrupted acquisitions, after a prior result of 400:
  - abort after 2 of 5 samples -> no result_valid, result stays 400, busy low next cycle.
  - A separate acquisition where abort coincides with the last-sample edge -> also no strobe.
- Reset: rst_n=0 for one cycle mid-acquisition -> all outputs 0 on the next cycle. A restarted acquisition of 2x50 gives result=100.

Source files
------------

// File: rtl/echo_accum.sv
// Count-terminated sample accumulator for echo stacking: sums n_samples valid
// inputs per acquisition with saturating or wrapping overflow and a sticky flag.
module echo_accum #(
  parameter int IN_W  = 12,
  parameter int ACC_W = 20,
  parameter int CNT_W = 10,
  parameter bit SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             abort,
  input  logic [IN_W-1:0]  din,
  input  logic             din_valid,
  output logic             busy,
  output logic [ACC_W-1:0] result,
  output logic             result_valid,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] n_lat_reg;
  logic             ovf_int_reg;
  logic [ACC_W-1:0] result_reg;
  logic             ovf_reg;
  logic             busy_reg;
  logic             result_valid_reg;

  logic [ACC_W:0]   sum_next;
  logic             carry_next;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt_next;

  // One extra bit catches the carry; a saturated acc simply re-saturates.
  assign sum_next   = {1'b0, acc_reg} + {{(ACC_W + 1 - IN_W){1'b0}}, din};
  assign carry_next = sum_next[ACC_W];
  assign acc_next   = (SAT && carry_next) ? {ACC_W{1'b1}} : sum_next[ACC_W-1:0];
  assign cnt_next   = cnt_reg + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      acc_reg          <= '0;
      cnt_reg          <= '0;
      n_lat_reg        <= '0;
      ovf_int_reg      <= 1'b0;
      result_reg       <= '0;
      ovf_reg          <= 1'b0;
      busy_reg         <= 1'b0;
      result_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          result_valid_reg <= 1'b0;
          if (start) begin
            n_lat_reg   <= n_samples;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            ovf_int_reg <= 1'b0;
            if (n_samples != '0) begin
              state_reg <= ACC;
              busy_reg  <= 1'b1;
            end else begin
              // Empty acquisition still reports a (zero) result.
              result_reg       <= '0;
              ovf_reg          <= 1'b0;
              state_reg        <= DONE;
              result_valid_reg <= 1'b1;
            end
          end
        end
        ACC: begin
          if (abort) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (din_valid) begin
            acc_reg     <= acc_next;
            cnt_reg     <= cnt_next;
            ovf_int_reg <= ovf_int_reg | carry_next;
            if (cnt_next == n_lat_reg) begin
              result_reg       <= acc_next;
              ovf_reg          <= ovf_int_reg | carry_next;
              state_reg        <= DONE;
              busy_reg         <= 1'b0;
              result_valid_reg <= 1'b1;
            end
          end
        end
        DONE: begin
          result_valid_reg <= 1'b0;
          state_reg        <= IDLE;
        end
        default: begin
          state_reg        <= IDLE;
          busy_reg         <= 1'b0;
          result_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_reg;
  assign result       = result_reg;
  assign result_valid = result_valid_reg;
  assign ovf          = ovf_reg;

endmodule

// File: tb/tb_echo_accum.sv
// Directed bench for echo_accum: a saturating and a wrapping instance share
// the same stimulus; expected values are hand-computed constants.
module tb_echo_accum;

  localparam int IN_W  = 12;
  localparam int ACC_W = 20;
  localparam int CNT_W = 10;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] n_samples;
  logic             abort;
  logic [IN_W-1:0]  din;
  logic             din_valid;

  logic             busy_s, busy_w;
  logic [ACC_W-1:0] result_s, result_w;
  logic             rv_s, rv_w;
  logic             ovf_s, ovf_w;

  int n_checks = 0;
  int n_errs   = 0;
  int rv_count = 0;
  int busy_cnt;
  int rv_before;

  echo_accum #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .SAT(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
    .abort(abort), .din(din), .din_valid(din_valid),
    .busy(busy_s), .result(result_s), .result_valid(rv_s), .ovf(ovf_s)
  );

  echo_accum #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
    .abort(abort), .din(din), .din_valid(din_valid),
    .busy(busy_w), .result(result_w), .result_valid(rv_w), .ovf(ovf_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rv_s) rv_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic do_start(input int n);
    start     = 1'b1;
    n_samples = CNT_W'(n);
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic send(input int val);
    din       = IN_W'(val);
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; n_samples = '0; abort = 1'b0;
    din = '0; din_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy_s}, 0);
    check("rst_result", {12'b0, result_s}, 0);
    check("rst_rv", {31'b0, rv_s}, 0);
    check("rst_ovf", {31'b0, ovf_s}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 4 x 100, no gaps
    do_start(4);
    busy_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      din = 12'd100; din_valid = 1'b1;
      if (busy_s) busy_cnt++;
      @(negedge clk);
    end
    din_valid = 1'b0;
    check("t1_busy_cycles", busy_cnt, 4);
    check("t1_rv", {31'b0, rv_s}, 1);
    check("t1_result", {12'b0, result_s}, 400);
    check("t1_ovf", {31'b0, ovf_s}, 0);
    check("t1_busy_done", {31'b0, busy_s}, 0);
    @(negedge clk);
    check("t1_rv_single", {31'b0, rv_s}, 0);

    // 7, 9, 11 with gaps 0, 2, 5 and stray starts during gaps
    do_start(3);
    send(7);
    repeat (2) begin start = 1'b1; n_samples = 10'd1; @(negedge clk); end
    start = 1'b0;
    send(9);
    repeat (5) begin start = 1'b1; n_samples = 10'd1; @(negedge clk); end
    start = 1'b0;
    send(11);
    check("t2_rv", {31'b0, rv_s}, 1);
    check("t2_result", {12'b0, result_s}, 27);
    @(negedge clk);

    // 300 x 4095: saturate vs wrap
    do_start(300);
    din = 12'd4095; din_valid = 1'b1;
    repeat (300) @(negedge clk);
    din_valid = 1'b0;
    check("t3_rv", {31'b0, rv_s}, 1);
    check("t3_sat_result", {12'b0, result_s}, 1048575);
    check("t3_sat_ovf", {31'b0, ovf_s}, 1);
    check("t3_wrap_result", {12'b0, result_w}, 179924);
    check("t3_wrap_ovf", {31'b0, ovf_w}, 1);
    @(negedge clk);
    do_start(2);
    send(1);
    send(1);
    check("t3b_sat_result", {12'b0, result_s}, 2);
    check("t3b_sat_ovf", {31'b0, ovf_s}, 0);
    check("t3b_wrap_result", {12'b0, result_w}, 2);
    check("t3b_wrap_ovf", {31'b0, ovf_w}, 0);
    @(negedge clk);

    // n_samples = 0
    check("t4_busy_pre", {31'b0, busy_s}, 0);
    do_start(0);
    check("t4_rv", {31'b0, rv_s}, 1);
    check("t4_result", {12'b0, result_s}, 0);
    check("t4_ovf", {31'b0, ovf_s}, 0);
    check("t4_busy", {31'b0, busy_s}, 0);
    @(negedge clk);

    // Establish 400, then abort after 2 of 5
    do_start(4);
    repeat (4) send(100);
    check("t5_prior", {12'b0, result_s}, 400);
    @(negedge clk);
    rv_before = rv_count;
    do_start(5);
    send(100);
    send(100);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_busy_after_abort", {31'b0, busy_s}, 0);
    repeat (3) @(negedge clk);
    check("t5_no_strobe", rv_count - rv_before, 0);
    check("t5_result_hold", {12'b0, result_s}, 400);

    // Abort coinciding with the last-sample edge
    rv_before = rv_count;
    do_start(2);
    send(100);
    din = 12'd100; din_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    din_valid = 1'b0; abort = 1'b0;
    check("t6_busy", {31'b0, busy_s}, 0);
    repeat (2) @(negedge clk);
    check("t6_no_strobe", rv_count - rv_before, 0);
    check("t6_result_hold", {12'b0, result_s}, 400);

    // Reset mid-acquisition, then 2 x 50
    do_start(4);
    send(50);
    send(50);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t7_busy", {31'b0, busy_s}, 0);
    check("t7_result", {12'b0, result_s}, 0);
    check("t7_rv", {31'b0, rv_s}, 0);
    check("t7_ovf", {31'b0, ovf_s}, 0);
    do_start(2);
    send(50);
    send(50);
    check("t7_rv_restart", {31'b0, rv_s}, 1);
    check("t7_result_restart", {12'b0, result_s}, 100);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
    $finish;
  end

endmodule
